// File: rtl/pixel_gen.sv
// Two-stage test-pattern generator: colour bars, checkerboard, bouncing box or solid colour.
// Syncs and blanking travel through the same two register stages so they stay aligned with RGB.
module pixel_gen #(
  parameter int H_disp = 1280,
  parameter int V_disp = 1024,
  parameter int BOX    = 64,
  parameter int STEP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_enable,
  input  logic [31:0] Xpix,
  input  logic [31:0] Ypix,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_n_out
);

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_BOX     = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [10:0] pos;
    logic        dir;
  } axis_t;

  localparam int                BAR_W  = H_disp / 8;
  localparam logic signed [12:0] X_LIM  = 13'(H_disp - BOX);
  localparam logic signed [12:0] Y_LIM  = 13'(V_disp - BOX);
  localparam logic signed [12:0] STEP_S = 13'(STEP);
  localparam logic [11:0]        BOX_W  = 12'(BOX);

  // Signed intermediate lets a step below zero be seen as negative instead of wrapping.
  function automatic axis_t bounce(input logic [10:0] pos, input logic dir,
                                   input logic signed [12:0] lim);
    axis_t             res;
    logic signed [12:0] nxt;
    nxt = dir ? $signed({2'b00, pos}) + STEP_S : $signed({2'b00, pos}) - STEP_S;
    if (nxt > lim) begin
      res.pos = lim[10:0];
      res.dir = 1'b0;
    end else if (nxt < 13'sd0) begin
      res.pos = '0;
      res.dir = 1'b1;
    end else begin
      res.pos = nxt[10:0];
      res.dir = dir;
    end
    return res;
  endfunction

  function automatic logic [23:0] bar_rgb(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  logic [10:0] x_in, y_in;
  logic        unused_bits;
  assign x_in        = Xpix[10:0];
  assign y_in        = Ypix[10:0];
  assign unused_bits = ^{Xpix[31:11], Ypix[31:11]};

  // Stage 1 state, frame state, stage 2 state.
  logic        en1_q, en1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [2:0]  bar_q, bar_d;
  logic        chk_q, chk_d, in_box_q, in_box_d;
  logic        vs_prev_q, vs_prev_d;
  mode_e       mode_q, mode_d;
  logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d, blank_q, blank_d;

  logic        frame_start;
  axis_t       step_x, step_y;

  assign frame_start = vs_prev_q & ~vsync_in;
  assign step_x      = bounce(box_x_q, dir_x_q, X_LIM);
  assign step_y      = bounce(box_y_q, dir_y_q, Y_LIM);

  always_comb begin
    // NOTE: every _d is given a value before any branch, so no path can infer a latch.
    en1_d     = disp_enable;
    hs1_d     = hsync_in;
    vs1_d     = vsync_in;
    vs_prev_d = vsync_in;
    chk_d     = x_in[5] ^ y_in[5];
    // Threshold scan saturates at bar 7, so out-of-range columns never index past the table.
    bar_d = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x_in) >= k * BAR_W) bar_d = 3'(k);
    end
    // Box hit uses the position held before any update on this edge.
    in_box_d = ({1'b0, x_in} >= {1'b0, box_x_q}) && ({1'b0, x_in} < {1'b0, box_x_q} + BOX_W) &&
               ({1'b0, y_in} >= {1'b0, box_y_q}) && ({1'b0, y_in} < {1'b0, box_y_q} + BOX_W);
    mode_d  = mode_q;
    box_x_d = box_x_q;
    dir_x_d = dir_x_q;
    box_y_d = box_y_q;
    dir_y_d = dir_y_q;
    if (frame_start) begin
      mode_d  = mode_e'(mode);
      box_x_d = step_x.pos;
      dir_x_d = step_x.dir;
      box_y_d = step_y.pos;
      dir_y_d = step_y.dir;
    end
  end

  always_comb begin
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    blank_d = en1_q;
    rgb_d   = '0;
    if (en1_q) begin
      case (mode_q)
        MODE_BARS:    rgb_d = bar_rgb(bar_q);
        MODE_CHECKER: rgb_d = chk_q ? 24'hFFFFFF : 24'h000000;
        MODE_BOX:     rgb_d = in_box_q ? 24'hFF0000 : 24'h000040;
        default:      rgb_d = solid_rgb;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst) begin
      en1_q     <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      bar_q     <= '0;
      chk_q     <= 1'b0;
      in_box_q  <= 1'b0;
      vs_prev_q <= 1'b1;
      mode_q    <= MODE_BARS;
      box_x_q   <= '0;
      box_y_q   <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      rgb_q     <= '0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      blank_q   <= 1'b0;
    end else begin
      en1_q     <= en1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      bar_q     <= bar_d;
      chk_q     <= chk_d;
      in_box_q  <= in_box_d;
      vs_prev_q <= vs_prev_d;
      mode_q    <= mode_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      rgb_q     <= rgb_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      blank_q   <= blank_d;
    end
  end

  assign R           = rgb_q[23:16];
  assign G           = rgb_q[15:8];
  assign B           = rgb_q[7:0];
  assign hsync_out   = hs2_q;
  assign vsync_out   = vs2_q;
  assign blank_n_out = blank_q;

endmodule

// File: tb/tb_pixel_gen.sv
// Directed bench for pixel_gen: bars, blanking/sync delay, mode latching, box bounce, mid-frame reset.
// A second instance with STEP=3 exercises the clamp from an odd start position.
module tb_pixel_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_enable;
  logic [31:0] Xpix, Ypix;
  logic        hsync_in, vsync_in;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [7:0]  R, G, B, R3, G3, B3;
  logic        hsync_out, vsync_out, blank_n_out;
  logic        hsync_out3, vsync_out3, blank_n_out3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  pixel_gen dut (
    .clk(clk), .rst(rst), .disp_enable(disp_enable), .Xpix(Xpix), .Ypix(Ypix),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .solid_rgb(solid_rgb),
    .R(R), .G(G), .B(B), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .blank_n_out(blank_n_out)
  );

  pixel_gen #(.STEP(3)) dut3 (
    .clk(clk), .rst(rst), .disp_enable(disp_enable), .Xpix(Xpix), .Ypix(Ypix),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .solid_rgb(solid_rgb),
    .R(R3), .G(G3), .B(B3), .hsync_out(hsync_out3), .vsync_out(vsync_out3),
    .blank_n_out(blank_n_out3)
  );

  always #5 clk = ~clk;

  task automatic drive(input int x, input int y, input logic en);
    Xpix        = 32'(x);
    Ypix        = 32'(y);
    disp_enable = en;
  endtask

  task automatic frame_start();
    @(negedge clk) vsync_in = 1'b0;
    @(negedge clk) vsync_in = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({R, G, B} !== 24'h0) $display("FAIL reset_rgb got=%h exp=000000", {R, G, B});
    else pass_cnt++;
    total_cnt++;
    if ({hsync_out, vsync_out, blank_n_out} !== 3'b110)
      $display("FAIL reset_sync_blank got=%b exp=110", {hsync_out, vsync_out, blank_n_out});
    else pass_cnt++;
    total_cnt++;
    if ({dut.box_x_q, dut.box_y_q} !== 22'h0)
      $display("FAIL reset_box got=(%0d,%0d) exp=(0,0)", dut.box_x_q, dut.box_y_q);
    else pass_cnt++;
    total_cnt++;
    if ({dut.dir_x_q, dut.dir_y_q, dut.vs_prev_q} !== 3'b111)
      $display("FAIL reset_dirs_vprev got=%b exp=111", {dut.dir_x_q, dut.dir_y_q, dut.vs_prev_q});
    else pass_cnt++;
    total_cnt++;
    if (2'(dut.mode_q) !== 2'd0) $display("FAIL reset_mode got=%0d exp=0", dut.mode_q);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  // Full line plus two columns past the active width, which must land on the black bar.
  task automatic test_color_bars();
    int          xs;
    logic [23:0] exp_rgb;
    mode = 2'd0;
    for (int i = 0; i < 1284; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        xs      = (i - 2 < 1280) ? i - 2 : ((i - 2 == 1280) ? 1300 : 2047);
        exp_rgb = BARS[(xs >= 1280) ? 7 : xs / 160];
        total_cnt++;
        if ({R, G, B} !== exp_rgb) $display("FAIL bars x=%0d got=%h exp=%h", xs, {R, G, B}, exp_rgb);
        else pass_cnt++;
      end
      if (i < 1280)       drive(i, 0, 1'b1);
      else if (i == 1280) drive(1300, 0, 1'b1);
      else if (i == 1281) drive(2047, 0, 1'b1);
      else                drive(0, 0, 1'b0);
    end
  endtask

  task automatic test_blank_sync();
    logic en_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic hs_v [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total_cnt++;
        if ({blank_n_out, hsync_out, vsync_out} !== {en_v[i-2], hs_v[i-2], 1'b1})
          $display("FAIL blank_sync step=%0d got=%b exp=%b", i - 2,
                   {blank_n_out, hsync_out, vsync_out}, {en_v[i-2], hs_v[i-2], 1'b1});
        else pass_cnt++;
        total_cnt++;
        if ({R, G, B} !== (en_v[i-2] ? 24'hFFFFFF : 24'h0))
          $display("FAIL blank_rgb step=%0d got=%h exp=%h", i - 2, {R, G, B},
                   en_v[i-2] ? 24'hFFFFFF : 24'h0);
        else pass_cnt++;
      end
      if (i < 5) begin
        drive(0, 0, en_v[i]);
        hsync_in = hs_v[i];
      end else begin
        drive(0, 0, 1'b0);
        hsync_in = 1'b1;
      end
    end
  endtask

  task automatic test_mode_switch();
    int          xs  [4] = '{32, 192, 32, 0};
    int          ys  [4] = '{0, 0, 32, 32};
    logic [23:0] exp [4] = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF};
    mode = 2'd1;
    @(negedge clk) drive(192, 0, 1'b1);
    @(negedge clk) drive(0, 0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if ({R, G, B} !== 24'hFFFF00) $display("FAIL mode_hold got=%h exp=FFFF00", {R, G, B});
    else pass_cnt++;
    frame_start();
    total_cnt++;
    if (2'(dut.mode_q) !== 2'd1) $display("FAIL mode_load got=%0d exp=1", dut.mode_q);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total_cnt++;
        if ({R, G, B} !== exp[i-2])
          $display("FAIL checker (%0d,%0d) got=%h exp=%h", xs[i-2], ys[i-2], {R, G, B}, exp[i-2]);
        else pass_cnt++;
      end
      if (i < 4) drive(xs[i], ys[i], 1'b1);
      else       drive(0, 0, 1'b0);
    end
  endtask

  task automatic test_bounce();
    int          xs  [4] = '{1216, 1215, 1279, 1216};
    int          ys  [4] = '{704, 704, 767, 768};
    logic [23:0] exp [4] = '{24'hFF0000, 24'h000040, 24'hFF0000, 24'h000040};
    do_reset();
    mode = 2'd2;
    repeat (405) frame_start();
    total_cnt++;
    if ({dut3.box_x_q, dut3.dir_x_q, dut.box_x_q} !== {11'd1215, 1'b1, 11'd810})
      $display("FAIL bounce_405 got=(%0d,%b,%0d) exp=(1215,1,810)",
               dut3.box_x_q, dut3.dir_x_q, dut.box_x_q);
    else pass_cnt++;
    frame_start();
    total_cnt++;
    if ({dut3.box_x_q, dut3.dir_x_q} !== {11'd1216, 1'b0})
      $display("FAIL step3_clamp got=(%0d,%b) exp=(1216,0)", dut3.box_x_q, dut3.dir_x_q);
    else pass_cnt++;
    repeat (203) frame_start();
    total_cnt++;
    if ({dut.box_x_q, dut.dir_x_q, dut.box_y_q, dut.dir_y_q} !== {11'd1216, 1'b0, 11'd704, 1'b0})
      $display("FAIL bounce_609 got=(%0d,%b,%0d,%b) exp=(1216,0,704,0)",
               dut.box_x_q, dut.dir_x_q, dut.box_y_q, dut.dir_y_q);
    else pass_cnt++;
    total_cnt++;
    if (2'(dut.mode_q) !== 2'd2) $display("FAIL bounce_mode got=%0d exp=2", dut.mode_q);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total_cnt++;
        if ({R, G, B} !== exp[i-2])
          $display("FAIL box_pix (%0d,%0d) got=%h exp=%h", xs[i-2], ys[i-2], {R, G, B}, exp[i-2]);
        else pass_cnt++;
      end
      if (i < 4) drive(xs[i], ys[i], 1'b1);
      else       drive(0, 0, 1'b0);
    end
    // Frame start while active: the pixel sampled on that edge still sees the old box.
    @(negedge clk) begin vsync_in = 1'b0; drive(1214, 704, 1'b1); end
    @(negedge clk) vsync_in = 1'b1;
    @(negedge clk) begin
      total_cnt++;
      if ({R, G, B} !== 24'h000040) $display("FAIL box_preupdate got=%h exp=000040", {R, G, B});
      else pass_cnt++;
      drive(0, 0, 1'b0);
    end
    @(negedge clk);
    total_cnt++;
    if ({R, G, B} !== 24'hFF0000) $display("FAIL box_postupdate got=%h exp=FF0000", {R, G, B});
    else pass_cnt++;
    total_cnt++;
    if ({dut.box_x_q, dut.dir_x_q, dut.box_y_q} !== {11'd1214, 1'b0, 11'd702})
      $display("FAIL bounce_610 got=(%0d,%b,%0d) exp=(1214,0,702)",
               dut.box_x_q, dut.dir_x_q, dut.box_y_q);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    mode      = 2'd3;
    solid_rgb = 24'h123456;
    frame_start();
    @(negedge clk) begin drive(100, 100, 1'b1); hsync_in = 1'b0; end
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({R, G, B, hsync_out} !== {24'h123456, 1'b0})
      $display("FAIL solid got=%h/%b exp=123456/0", {R, G, B}, hsync_out);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({R, G, B} !== 24'h0) $display("FAIL midreset_rgb got=%h exp=000000", {R, G, B});
    else pass_cnt++;
    total_cnt++;
    if ({hsync_out, vsync_out, blank_n_out} !== 3'b110)
      $display("FAIL midreset_sync got=%b exp=110", {hsync_out, vsync_out, blank_n_out});
    else pass_cnt++;
    total_cnt++;
    if ({dut.box_x_q, dut.box_y_q, 2'(dut.mode_q)} !== 24'h0)
      $display("FAIL midreset_state got=(%0d,%0d,%0d) exp=(0,0,0)",
               dut.box_x_q, dut.box_y_q, dut.mode_q);
    else pass_cnt++;
    rst      = 1'b0;
    hsync_in = 1'b1;
    drive(0, 0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    mode        = 2'd0;
    solid_rgb   = 24'h0;
    drive(0, 0, 1'b0);
    test_reset();
    test_color_bars();
    test_blank_sync();
    test_mode_switch();
    test_bounce();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
